// File: rtl/ssd_scan_ctrl_if.sv
// Bus between game/status logic and the seven-segment scan controller:
// value/load request, live display controls and the anode/cathode pins.
interface ssd_scan_ctrl_if #(
    parameter int N_DIGITS = 8,
    parameter int VALUE_W  = 8,
    parameter int PWM_W    = 4
);
    // Handshake: Load is a one-cycle request carrying Value/Hex_Mode and is
    // taken only while Busy=0; a Load seen while Busy=1 (including the final
    // result-copy cycle) is dropped, never queued. Digits_Valid rises with the
    // first completed conversion and stays high until reset.
    logic [VALUE_W-1:0]  Value;
    logic                Load;
    logic                Hex_Mode;
    logic                Blank_Lz;
    logic [PWM_W-1:0]    Brightness;
    logic [N_DIGITS-1:0] Dp_Mask;
    logic                Busy;
    logic                Digits_Valid;
    logic                Overflow;
    logic [N_DIGITS-1:0] An;
    logic [7:0]          Cathodes;
    logic [1:0]          State_Dbg;

    modport master (
        output Value, Load, Hex_Mode, Blank_Lz, Brightness, Dp_Mask,
        input  Busy, Digits_Valid, Overflow, An, Cathodes, State_Dbg
    );

    modport slave (
        input  Value, Load, Hex_Mode, Blank_Lz, Brightness, Dp_Mask,
        output Busy, Digits_Valid, Overflow, An, Cathodes, State_Dbg
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multi-digit seven-segment scan controller: sequential double-dabble BCD or
// hex conversion into a shadow register, leading-zero blanking, DP and PWM dimming.
module ssd_scan_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int VALUE_W  = 8,
    parameter int SCAN_DIV = 18,
    parameter int PWM_W    = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    ssd_scan_ctrl_if.slave bus
);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int EXT_W = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [VALUE_W-1:0] val_q, val_nxt;
    logic               hex_q, hex_nxt;
    logic [BCD_W-1:0]   bcd_q, bcd_nxt;
    logic               ovf_q, ovf_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [BCD_W-1:0]   shadow_q, shadow_nxt;
    logic               valid_q, valid_nxt;
    logic               ovf_out_q, ovf_out_nxt;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_sh;
    logic [VALUE_W-1:0] val_sh;
    logic               shift_out;
    logic [EXT_W-1:0]   hex_ext;

    function automatic logic [6:0] hex_to_ssd(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // One double-dabble step: correct each nibble, then shift {BCD,value} left.
    always_comb begin : dabble
        for (int i = 0; i < N_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
        {shift_out, bcd_sh, val_sh} = {bcd_adj, val_q, 1'b0};
        hex_ext = EXT_W'(val_q);
    end

    always_comb begin : fsm_next
        state_nxt   = state;
        val_nxt     = val_q;
        hex_nxt     = hex_q;
        bcd_nxt     = bcd_q;
        ovf_nxt     = ovf_q;
        cnt_nxt     = cnt_q;
        shadow_nxt  = shadow_q;
        valid_nxt   = valid_q;
        ovf_out_nxt = ovf_out_q;
        case (state)
            IDLE: begin
                if (bus.Load) begin
                    val_nxt   = bus.Value;
                    hex_nxt   = bus.Hex_Mode;
                    bcd_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = bus.Hex_Mode ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt = bcd_sh;
                val_nxt = val_sh;
                ovf_nxt = ovf_q | shift_out;
                cnt_nxt = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VALUE_W - 1)) state_nxt = DONE;
            end
            DONE: begin
                shadow_nxt  = hex_q ? hex_ext[BCD_W-1:0] : bcd_q;
                ovf_out_nxt = ~hex_q & ovf_q;
                valid_nxt   = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            val_q     <= '0;
            hex_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            valid_q   <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            val_q     <= val_nxt;
            hex_q     <= hex_nxt;
            bcd_q     <= bcd_nxt;
            ovf_q     <= ovf_nxt;
            cnt_q     <= cnt_nxt;
            shadow_q  <= shadow_nxt;
            valid_q   <= valid_nxt;
            ovf_out_q <= ovf_out_nxt;
        end
    end

    logic [SCAN_DIV-1:0] presc_q;
    logic [IDX_W-1:0]    idx_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (presc_q == '1) idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    logic [3:0]          nib [N_DIGITS];
    logic [N_DIGITS-1:0] zero_from;
    logic                zero_acc;
    logic [3:0]          nib_sel;
    logic [PWM_W-1:0]    phase;
    logic                pwm_on, blank_sel, dp_sel, lit;
    logic [6:0]          seg_sel;
    logic [N_DIGITS-1:0] an_nxt, an_q;
    logic [7:0]          cath_nxt, cath_q;

    always_comb begin : display
        zero_acc = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nib[i]       = shadow_q[4*i +: 4];
            zero_acc     = zero_acc & (nib[i] == 4'd0);
            zero_from[i] = zero_acc;
        end
        nib_sel   = nib[idx_q];
        blank_sel = bus.Blank_Lz && (idx_q != '0) && zero_from[idx_q];
        dp_sel    = bus.Dp_Mask[idx_q];
        phase     = presc_q[SCAN_DIV-1 -: PWM_W];
        pwm_on    = (bus.Brightness == '1) || (phase < bus.Brightness);
        if (ovf_out_q)      seg_sel = 7'b1111110;
        else if (blank_sel) seg_sel = 7'b1111111;
        else                seg_sel = hex_to_ssd(nib_sel);
        // A blanked digit keeps its anode only to show a requested DP.
        lit      = valid_q & pwm_on & (ovf_out_q | ~blank_sel | dp_sel);
        an_nxt   = '1;
        if (lit) an_nxt[idx_q] = 1'b0;
        cath_nxt = valid_q ? {seg_sel, ~dp_sel} : 8'hFF;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            an_q   <= '1;
            cath_q <= 8'hFF;
        end else begin
            an_q   <= an_nxt;
            cath_q <= cath_nxt;
        end
    end

    assign bus.Busy         = (state != IDLE);
    assign bus.Digits_Valid = valid_q;
    assign bus.Overflow     = ovf_out_q;
    assign bus.An           = an_q;
    assign bus.Cathodes     = cath_q;
    assign bus.State_Dbg    = state;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: a 4-digit and a 2-digit instance share stimulus and
// are checked every cycle against a value/time-level display model.
module tb_ssd_scan_ctrl;
    localparam int VALUE_W  = 8;
    localparam int SCAN_DIV = 4;
    localparam int PWM_W    = 2;
    localparam int SCAN_LEN = 1 << SCAN_DIV;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [7:0] value;
    logic       load, hex, blank;
    logic [1:0] bright;
    logic [7:0] dp;

    ssd_scan_ctrl_if #(.N_DIGITS(4), .VALUE_W(VALUE_W), .PWM_W(PWM_W)) bus4 ();
    ssd_scan_ctrl_if #(.N_DIGITS(2), .VALUE_W(VALUE_W), .PWM_W(PWM_W)) bus2 ();

    assign bus4.Value = value;      assign bus2.Value = value;
    assign bus4.Load = load;        assign bus2.Load = load;
    assign bus4.Hex_Mode = hex;     assign bus2.Hex_Mode = hex;
    assign bus4.Blank_Lz = blank;   assign bus2.Blank_Lz = blank;
    assign bus4.Brightness = bright; assign bus2.Brightness = bright;
    assign bus4.Dp_Mask = dp[3:0];  assign bus2.Dp_Mask = dp[1:0];

    ssd_scan_ctrl #(.N_DIGITS(4), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV), .PWM_W(PWM_W))
        dut4 (.Clk(clk), .Reset(rst_n), .bus(bus4.slave));
    ssd_scan_ctrl #(.N_DIGITS(2), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV), .PWM_W(PWM_W))
        dut2 (.Clk(clk), .Reset(rst_n), .bus(bus2.slave));

    int n_total = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // model: what each display should show, derived from the value itself
    typedef struct packed {
        logic            valid;
        logic            ovf;
        logic [7:0][3:0] dig;
    } disp_t;

    disp_t cur_m [2];
    disp_t pend_m [2];
    logic  pend_v [2];
    int    done_at [2];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic disp_t convert(input int v, input logic hx, input int n);
        disp_t r;
        int p, lim;
        r = '0;
        r.valid = 1'b1;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            r.dig[i] = hx ? 4'((v >> (4 * i)) & 15) : 4'((v / p) % 10);
            p = p * 10;
        end
        lim = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        r.ovf = !hx && (v >= lim);
        return r;
    endfunction

    // registered An/Cathodes after edge k, from the display state after edge k-1
    function automatic logic [15:0] exp_scan(input disp_t d, input int n, input int k,
                                             input logic blk, input logic [1:0] br,
                                             input logic [7:0] dpm);
        int p, idx, ph;
        logic on, blanked, dpi;
        logic [6:0] seg;
        logic [7:0] an;
        if (!d.valid) return 16'hFFFF;
        p   = (k - 1) % SCAN_LEN;
        idx = ((k - 1) / SCAN_LEN) % n;
        ph  = p / (SCAN_LEN >> PWM_W);
        on  = (br == 2'd3) || (ph < int'(br));
        blanked = blk && (idx > 0);
        for (int j = idx; j < n; j++) if (d.dig[j] != 4'd0) blanked = 1'b0;
        dpi = dpm[idx];
        if (d.ovf)         seg = 7'b1111110;
        else if (blanked)  seg = 7'b1111111;
        else               seg = seg7(d.dig[idx]);
        an = 8'hFF;
        if (on && (d.ovf || !blanked || dpi)) an[idx] = 1'b0;
        return {an, seg, ~dpi};
    endfunction

    // scoreboard: compare both instances every cycle
    disp_t       prev_disp;
    logic        prev_busy;
    logic [18:0] act, expv;
    int          n_dig;
    string       nm;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                n_dig = 4;
                nm = "dut4 scan";
                act = {bus4.Busy, bus4.Digits_Valid, bus4.Overflow, 4'hF, bus4.An, bus4.Cathodes};
            end else begin
                n_dig = 2;
                nm = "dut2 scan";
                act = {bus2.Busy, bus2.Digits_Valid, bus2.Overflow, 6'h3F, bus2.An, bus2.Cathodes};
            end
            if (!rst_n) begin
                cur_m[d]  = '0;
                pend_v[d] = 1'b0;
                expv = {3'b000, 8'hFF, 8'hFF};
            end else begin
                prev_disp = cur_m[d];
                prev_busy = pend_v[d];
                if (pend_v[d] && cyc >= done_at[d]) begin
                    cur_m[d]  = pend_m[d];
                    pend_v[d] = 1'b0;
                end
                if (load && !prev_busy) begin
                    pend_v[d]  = 1'b1;
                    pend_m[d]  = convert(int'(value), hex, n_dig);
                    done_at[d] = cyc + (hex ? 1 : VALUE_W + 1);
                end
                expv = {pend_v[d], cur_m[d].valid, cur_m[d].ovf,
                        exp_scan(prev_disp, n_dig, cyc, blank, bright, dp)};
            end
            check(nm, 32'(act), 32'(expv));
        end
    end

    // driver tasks
    int lo4 [4];
    logic [7:0] sg4 [4];
    int lo2 [2];
    logic [7:0] sg2 [2];
    int nb;

    task automatic set_live(input logic b, input logic [1:0] br, input logic [7:0] dpm);
        @(negedge clk);
        #1;
        blank = b; bright = br; dp = dpm;
    endtask

    task automatic pulse_load(input logic [7:0] v, input logic h);
        @(negedge clk);
        #1;
        value = v; hex = h; load = 1'b1;
        @(negedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic load_count(input logic [7:0] v, input logic h, output int busy_n);
        @(negedge clk);
        #1;
        value = v; hex = h; load = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus4.Busy) busy_n++;
            if (i == 0) begin
                #1;
                load = 1'b0;
            end
        end
    endtask

    task automatic observe(input int ncyc);
        for (int i = 0; i < 4; i++) begin lo4[i] = 0; sg4[i] = 8'hFF; end
        for (int i = 0; i < 2; i++) begin lo2[i] = 0; sg2[i] = 8'hFF; end
        repeat (ncyc) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (!bus4.An[i]) begin lo4[i]++; sg4[i] = bus4.Cathodes; end
            for (int i = 0; i < 2; i++) if (!bus2.An[i]) begin lo2[i]++; sg2[i] = bus2.Cathodes; end
        end
    endtask

    initial begin
        value = '0; load = 1'b0; hex = 1'b0; blank = 1'b0; bright = 2'd3; dp = '0;
        repeat (3) @(negedge clk);
        check("reset dut4", {bus4.Busy, bus4.Digits_Valid, bus4.Overflow, bus4.An, bus4.Cathodes},
              {3'b000, 4'hF, 8'hFF});
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("dark before load", 32'(bus4.An), 32'hF);

        // decimal 225 on four digits
        load_count(8'd225, 1'b0, nb);
        check("busy cycles dec", nb, 9);
        check("valid after dec", 32'(bus4.Digits_Valid), 1);
        check("ovf 225", 32'(bus4.Overflow), 0);
        observe(64);
        check("225 digit0", sg4[0], 8'b01001001);
        check("225 digit1", sg4[1], 8'b00100101);
        check("225 digit2", sg4[2], 8'b00100101);
        check("225 digit3", sg4[3], 8'b00000011);
        check("225 full on", lo4[3], 16);

        // leading-zero blanking and DP on a blanked digit
        set_live(1'b1, 2'd3, 8'h00);
        load_count(8'd7, 1'b0, nb);
        observe(64);
        check("7 digit0 lit", lo4[0], 16);
        check("7 upper dark", lo4[1] + lo4[2] + lo4[3], 0);
        check("7 digit0 seg", sg4[0], 8'b00011111);
        set_live(1'b1, 2'd3, 8'b0100);
        observe(64);
        check("dp blank lit", lo4[2], 16);
        check("dp blank seg", sg4[2], 8'hFE);
        check("dp others dark", lo4[1] + lo4[3], 0);

        // two-digit overflow then recovery
        set_live(1'b0, 2'd3, 8'h00);
        load_count(8'd150, 1'b0, nb);
        check("ovf 150 n2", 32'(bus2.Overflow), 1);
        observe(64);
        check("150 dash0", sg2[0], 8'b11111101);
        check("150 dash1", sg2[1], 8'b11111101);
        load_count(8'd42, 1'b0, nb);
        check("ovf 42 n2", 32'(bus2.Overflow), 0);
        observe(64);
        check("42 digit1", sg2[1], 8'b10011001);
        check("42 digit0", sg2[0], 8'b00100101);

        // hex mode
        load_count(8'hAB, 1'b1, nb);
        check("busy cycles hex", nb, 1);
        observe(64);
        check("hex digit0", sg4[0], 8'b11000001);
        check("hex digit1", sg4[1], 8'b00010001);
        check("hex digit3", sg4[3], 8'b00000011);
        set_live(1'b1, 2'd3, 8'h00);
        observe(64);
        check("hex blank upper", lo4[3] + lo4[2], 0);
        check("hex digit1 lit", lo4[1], 16);

        // PWM dimming
        set_live(1'b0, 2'd1, 8'h00);
        observe(64);
        for (int i = 0; i < 4; i++) check("pwm quarter", lo4[i], 4);
        set_live(1'b0, 2'd0, 8'h00);
        observe(64);
        check("pwm dark", lo4[0] + lo4[1] + lo4[2] + lo4[3], 0);

        // load during conversion is dropped
        set_live(1'b0, 2'd3, 8'h00);
        pulse_load(8'd225, 1'b0);
        @(negedge clk);
        pulse_load(8'd99, 1'b0);
        repeat (20) @(negedge clk);
        observe(64);
        check("drop digit0", sg4[0], 8'b01001001);
        check("drop digit1", sg4[1], 8'b00100101);

        // reset mid-conversion
        pulse_load(8'd42, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort dut4", {bus4.Busy, bus4.Digits_Valid, bus4.Overflow, bus4.An, bus4.Cathodes},
              {3'b000, 4'hF, 8'hFF});
        check("abort dut2", {bus2.Busy, bus2.Digits_Valid, bus2.Overflow, bus2.An, bus2.Cathodes},
              {3'b000, 2'h3, 8'hFF});
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        observe(64);
        check("dark after abort", lo4[0] + lo4[1] + lo4[2] + lo4[3], 0);
        check("invalid after abort", 32'(bus4.Digits_Valid), 0);
        load_count(8'd7, 1'b0, nb);
        observe(64);
        check("relit digit0", sg4[0], 8'b00011111);
        check("relit digit3", lo4[3], 16);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Parametrised multi-digit seven-segment display controller. Successor to the fixed 4-digit SSD scan logic in the game top level.
- Takes a binary value and converts it to BCD with a sequential double-dabble engine, or displays it as hex nibbles.
- Blanks leading zeros, applies per-digit decimal points and PWM-dims the display.
- Sits between game/status logic and the board anode/cathode pins.

Parameters:
- N_DIGITS, 8: number of digits/anodes driven (2..8).
- VALUE_W, 8: width of the binary input value.
- SCAN_DIV, 18: each digit is selected for 2^SCAN_DIV clocks.
- PWM_W, 4: brightness resolution in bits (PWM_W <= SCAN_DIV).

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: asynchronous, active-low reset.
- Value, in, VALUE_W: binary value to display; sampled on an accepted Load.
- Load, in, 1: single-cycle request to convert and display Value.
- Hex_Mode, in, 1: sampled with Value. 1 = hex nibbles, 0 = decimal.
- Blank_Lz, in, 1: live input. 1 = blank leading zero digits.
- Brightness, in, PWM_W: live duty control.
- Dp_Mask, in, N_DIGITS: live input. Bit i = 1 lights the decimal point of digit i.
- Busy, out, 1: conversion in progress.
- Digits_Valid, out, 1: sticky; set after the first completed conversion.
- Overflow, out, 1: the last decimal conversion exceeded N_DIGITS digits.
- An, out, N_DIGITS: anodes, active-low. An[0] is the rightmost digit.
- Cathodes, out, 8: {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

Behaviour:
- Reset (asynchronous, Reset=0) values:
  - FSM = IDLE; Busy=0, Digits_Valid=0, Overflow=0.
  - An = all ones, Cathodes = 8'hFF.
  - Prescaler=0, digit index=0, shadow digit register=0.
- Reset asserted mid-conversion aborts it; no partial result is ever displayed.
- FSM states:
  - IDLE: Load=1 latches Value, Hex_Mode and clears the BCD work register (4*N_DIGITS bits) and the overflow flag. Next state is SHIFT if Hex_Mode=0, else DONE. Busy=1 from the next cycle.
  - SHIFT: VALUE_W cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift {BCD,Value} left by 1. Any 1 shifted out of the BCD MSB sets the overflow flag (sticky for this conversion).
  - DONE: one cycle. Copies the result into the shadow register atomically: BCD result, or zero-extended Value nibbles in hex mode, truncated to N_DIGITS. Sets Digits_Valid=1. Overflow = flag (always 0 in hex mode). Busy=0 next cycle. Returns to IDLE.
- Latency, Load to shadow update: VALUE_W+2 cycles in decimal mode, 2 cycles in hex mode.
- Load while Busy=1 is ignored (dropped, not queued). Load in the same cycle DONE is active is also dropped.
- Scan timing:
  - The SCAN_DIV-bit prescaler free-runs.
  - On prescaler wrap, the digit index increments and wraps from N_DIGITS-1 to 0, including non-power-of-two N_DIGITS.
- PWM:
  - Phase = prescaler[SCAN_DIV-1 -: PWM_W].
  - The selected anode is active when phase < Brightness. Brightness = all ones means always active; Brightness = 0 means dark.
- Digit content, digit i = shadow nibble i:
  - If Overflow=1, every digit shows '-' (Cg only).
  - Blanking (Blank_Lz=1): digit i (i >= 1) is blank when nibbles i..N_DIGITS-1 are all zero. Digit 0 is never blanked.
  - A blanked digit still shows its DP if Dp_Mask[i]=1.
- Segment encoding: hex 0-F with the same patterns as the existing HEX_TO_SSD decoder.
- While Digits_Valid=0, An stays all ones.
- An and Cathodes are registered: they reflect the index/phase/shadow from the previous cycle. At most one An bit is low at any time.

Test Plan:
- N_DIGITS=4, VALUE_W=8, SCAN_DIV=4, PWM_W=2, Brightness=3. Load Value=8'd225, Hex_Mode=0 -> Busy for 9 cycles then clears; Digits_Valid=1; scan shows digits 0,2,2,5. The Ca..Dp pattern for 5 is 8'b01001001. Overflow=0.
- Same setup with Blank_Lz=1, Value=8'd7 -> only An[0] ever goes low (digit 7). Digits 1-3 blank. With Dp_Mask=4'b0100, An[2] goes low with Cathodes=8'hFE.
- N_DIGITS=2, Value=8'd150 decimal -> Overflow=1 and both digits show 8'b11111101. A following Load with Value=8'd42 -> Overflow=0, displays 4,2.
- Hex_Mode=1, Value=8'hAB, N_DIGITS=4 -> result after 2 cycles. Shows 0,0,A,B, or blank,blank,A,B with Blank_Lz=1.
- Brightness=1, PWM_W=2 -> selected anode is low for 4 of 16 prescaler cycles per digit. Brightness=0 -> An stays all ones.
- Load at cycle 3 of SHIFT is ignored (result matches the first value). Reset pulsed low mid-SHIFT -> all outputs return to reset values immediately; display stays dark until the next Load completes.
